lcd_frame_monitor: RTL and testbench
====================================

Name: lcd_frame_monitor

Overview:
- Parametrised, synthesizable successor to the bench-side LCD capture counters.
- Tracks MTL-style DE-less video (active-low HSD/VSD plus 24-bit RGB) on the LCD pixel clock.
- Locks to sync edges and checks the sync period against the configured timing.
- Emits a registered pixel stream with active-window coordinates, per-frame events and a frame counter, for on-chip frame grabbers and self-check logic.

Parameters:
H_TOTAL, 1056, pixel clocks per line
V_TOTAL, 525, lines per frame
H_ACT_START, 50, first active x (in line-relative counts)
H_ACT_W, 800, active pixels per line
V_ACT_START, 23, first active line
V_ACT_H, 480, active lines
XW, 11, width of x counters and o_pix_x
YW, 10, width of y counters and o_pix_y
FCNT_W, 16, frame counter width
LOCK_FRAMES, 2, consecutive clean frames required to lock (1..15)

Ports:
i_clk  in  1  LCD pixel clock (MTL_DCLK domain)
i_rstn  in  1  asynchronous active-low reset
i_hsd  in  1  horizontal sync, active low
i_vsd  in  1  vertical sync, active low
i_rgb  in  24  {R,G,B} pixel sample
o_locked  out  1  monitor in LOCKED state
o_pix_vld  out  1  active-window pixel valid
o_pix_x  out  XW  x relative to H_ACT_START
o_pix_y  out  YW  y relative to V_ACT_START
o_pix_rgb  out  24  registered pixel
o_frame_done  out  1  one-cycle pulse with the last active pixel
o_frame_cnt  out  FCNT_W  completed locked frames, wraps
o_err_h  out  1  one-cycle pulse, HSD period error
o_err_v  out  1  one-cycle pulse, VSD period error
o_frame_crc  out  16  CRC of the last completed frame (see Optional Feature)

Behaviour:
- Reset (i_rstn=0, async) clears all outputs to 0, the state to SEARCH, the counters to 0 and the sync history registers to 1.
- Edge detection: fall_h = r_hsd & ~i_hsd; fall_v = r_vsd & ~i_vsd. r_hsd and r_vsd are 1-cycle delayed copies of the inputs.
- Sample position (x,y) of the current input:
  - x = 0 on a fall_h sample. Otherwise x = x_prev+1, wrapping from H_TOTAL-1 to 0 (free-running if no HSD).
  - y = 0 on a fall_v sample. Otherwise y increments on every x=0 sample, wrapping from V_TOTAL-1 to 0.
- Period checks, active in TRACK and LOCKED only:
  - err_h when fall_h occurs and x_prev != H_TOTAL-1.
  - err_v when fall_v occurs and the position is not the wrap point (y_prev != V_TOTAL-1, or x_prev != H_TOTAL-1).
  - The counters realign to the edge regardless of error.
  - o_err_h and o_err_v are registered, 1 cycle after the offending sample.
- State machine:
  - SEARCH -> TRACK on first fall_v; clean count = 0; no errors raised in SEARCH.
  - TRACK: each fall_v with no error since the previous fall_v increments clean. When clean reaches LOCK_FRAMES, go to LOCKED. Any error clears clean.
  - LOCKED -> TRACK on any err_h or err_v. clean = 0; o_locked drops in the same cycle the error pulse is output.
- Pixel output: in LOCKED, when H_ACT_START <= x < H_ACT_START+H_ACT_W and V_ACT_START <= y < V_ACT_START+V_ACT_H:
  - The next cycle carries o_pix_vld=1, o_pix_x = x-H_ACT_START, o_pix_y = y-V_ACT_START, o_pix_rgb = i_rgb.
  - Latency is 1 cycle.
  - Otherwise o_pix_vld=0 and the data outputs hold their previous values.
- o_frame_done asserts together with the o_pix_vld of the pixel at (H_ACT_W-1, V_ACT_H-1). o_frame_cnt increments in that same cycle, wrapping at 2^FCNT_W.
  - A frame interrupted by loss of lock emits no o_frame_done.
  - A frame entered mid-way, with lock gained at a fall_v, is complete by construction.
- Simultaneous fall_h and fall_v: y=0 and x=0; both checks are evaluated. On error, both pulses may fire in the same cycle.
- Reset mid-frame: returns to SEARCH immediately; no partial frame_done is issued.

Optional Feature:
- Macro LCD_MONITOR_FRAME_CRC_EN.
- Defined:
  - CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB first) is accumulated over the 24-bit o_pix_rgb of every valid pixel in raster order, 3 bytes per pixel, R first, computed in 1 cycle.
  - The accumulator is reinitialised on the first active pixel of each frame and whenever lock is lost.
  - o_frame_crc updates 1 cycle after o_frame_done and holds until the next completion.
- Undefined: o_frame_crc is tied to 16'h0 and no CRC logic is built.

Test Plan:
- Nominal 1056x525 timing, clean syncs from reset, rgb = {x[7:0],y[7:0],8'hA5} -> o_locked rises at the 3rd fall_v. The next frame gives exactly 384000 o_pix_vld, first at (0,0), last at (799,479) with o_frame_done=1, and o_frame_cnt=1.
- Period error: one line in a locked frame with HSD at 1055 clocks -> o_err_h pulses once, o_locked drops, pixels stop, no frame_done for that frame. Relock after 2 clean frames.
- Short frame: VSD fall at line 500 while locked -> o_err_v pulse, y realigns to 0, state TRACK, o_frame_cnt unchanged.
- Async reset mid-line (x=400,y=200) -> all outputs 0 the same instant; after release, no error pulse on the first fall_v; SEARCH->TRACK.
- Free-run without HSD for 2 lines after lock -> x wraps 1055->0 internally with no error; a correct HSD edge later raises no error.
- With LCD_MONITOR_FRAME_CRC_EN and a constant rgb of 24'h000000 -> o_frame_crc is identical for two consecutive frames and matches the software model. Without the macro, o_frame_crc stays 0.

Source files
------------

// File: rtl/lcd_frame_monitor.sv
// Sync-locking monitor for DE-less LCD video: tracks HSD/VSD, checks periods, emits active-window pixels.
// Optional frame CRC is built when LCD_MONITOR_FRAME_CRC_EN is defined.
module lcd_frame_monitor #(
    parameter int unsigned H_TOTAL     = 1056,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned H_ACT_START = 50,
    parameter int unsigned H_ACT_W     = 800,
    parameter int unsigned V_ACT_START = 23,
    parameter int unsigned V_ACT_H     = 480,
    parameter int unsigned XW          = 11,
    parameter int unsigned YW          = 10,
    parameter int unsigned FCNT_W      = 16,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_hsd,
    input  logic              i_vsd,
    input  logic [23:0]       i_rgb,
    output logic              o_locked,
    output logic              o_pix_vld,
    output logic [XW-1:0]     o_pix_x,
    output logic [YW-1:0]     o_pix_y,
    output logic [23:0]       o_pix_rgb,
    output logic              o_frame_done,
    output logic [FCNT_W-1:0] o_frame_cnt,
    output logic              o_err_h,
    output logic              o_err_v,
    output logic [15:0]       o_frame_crc
);

    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t        state;
    logic          r_hsd;
    logic          r_vsd;
    logic [XW-1:0] x_prev;
    logic [YW-1:0] y_prev;
    logic [CW-1:0] clean;
    logic          dirty;

    logic          fall_h;
    logic          fall_v;
    logic [XW-1:0] x_cur;
    logic [YW-1:0] y_cur;
    logic          err_h;
    logic          err_v;
    logic          err_any;
    logic          lock_gain;
    logic          locked_nxt;
    logic          in_win;
    logic          pix_take;
    logic [XW-1:0] x_rel;
    logic [YW-1:0] y_rel;
    logic          last_pix;
    logic          first_pix;

    // Position of the current sample, period checks and lock qualification
    always_comb begin
        fall_h = r_hsd & ~i_hsd;
        fall_v = r_vsd & ~i_vsd;

        if (fall_h || (x_prev == XW'(H_TOTAL - 1))) begin
            x_cur = '0;
        end else begin
            x_cur = x_prev + XW'(1);
        end

        if (fall_v) begin
            y_cur = '0;
        end else if (x_cur == '0) begin
            y_cur = (y_prev == YW'(V_TOTAL - 1)) ? '0 : y_prev + YW'(1);
        end else begin
            y_cur = y_prev;
        end

        err_h   = (state != SEARCH) && fall_h && (x_prev != XW'(H_TOTAL - 1));
        err_v   = (state != SEARCH) && fall_v &&
                  ((y_prev != YW'(V_TOTAL - 1)) || (x_prev != XW'(H_TOTAL - 1)));
        err_any = err_h | err_v;

        lock_gain  = (state == TRACK) && fall_v && !err_any && !dirty &&
                     ((clean + CW'(1)) >= CW'(LOCK_FRAMES));
        locked_nxt = ((state == LOCKED) && !err_any) || lock_gain;

        in_win = (x_cur >= XW'(H_ACT_START)) && (x_cur < XW'(H_ACT_START + H_ACT_W)) &&
                 (y_cur >= YW'(V_ACT_START)) && (y_cur < YW'(V_ACT_START + V_ACT_H));
        pix_take  = locked_nxt && in_win;
        x_rel     = x_cur - XW'(H_ACT_START);
        y_rel     = y_cur - YW'(V_ACT_START);
        last_pix  = (x_rel == XW'(H_ACT_W - 1)) && (y_rel == YW'(V_ACT_H - 1));
        first_pix = (x_rel == '0) && (y_rel == '0);
    end

    // Sync history, position counters and lock state machine
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state  <= SEARCH;
            r_hsd  <= 1'b1;
            r_vsd  <= 1'b1;
            x_prev <= '0;
            y_prev <= '0;
            clean  <= '0;
            dirty  <= 1'b0;
        end else begin
            r_hsd  <= i_hsd;
            r_vsd  <= i_vsd;
            x_prev <= x_cur;
            y_prev <= y_cur;
            case (state)
                SEARCH: begin
                    if (fall_v) begin
                        state <= TRACK;
                        clean <= '0;
                        dirty <= 1'b0;
                    end
                end
                TRACK: begin
                    if (lock_gain) begin
                        state <= LOCKED;
                        clean <= '0;
                        dirty <= 1'b0;
                    end else if (fall_v) begin
                        // A frame counts only if its whole interval was error-free
                        clean <= (err_any || dirty) ? '0 : clean + CW'(1);
                        dirty <= 1'b0;
                    end else if (err_any) begin
                        clean <= '0;
                        dirty <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (err_any) begin
                        state <= TRACK;
                        clean <= '0;
                        dirty <= !fall_v;
                    end
                end
                default: begin
                    state <= SEARCH;
                    clean <= '0;
                    dirty <= 1'b0;
                end
            endcase
        end
    end

    // Registered pixel stream, events and frame counter
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_locked     <= 1'b0;
            o_pix_vld    <= 1'b0;
            o_pix_x      <= '0;
            o_pix_y      <= '0;
            o_pix_rgb    <= '0;
            o_frame_done <= 1'b0;
            o_frame_cnt  <= '0;
            o_err_h      <= 1'b0;
            o_err_v      <= 1'b0;
        end else begin
            o_locked     <= locked_nxt;
            o_err_h      <= err_h;
            o_err_v      <= err_v;
            o_pix_vld    <= pix_take;
            o_frame_done <= pix_take && last_pix;
            if (pix_take) begin
                o_pix_x   <= x_rel;
                o_pix_y   <= y_rel;
                o_pix_rgb <= i_rgb;
                if (last_pix) begin
                    o_frame_cnt <= o_frame_cnt + FCNT_W'(1);
                end
            end
        end
    end

`ifdef LCD_MONITOR_FRAME_CRC_EN
    logic [15:0] crc_acc;

    // CRC-16-CCITT over 24 bits, MSB (R[7]) first
    function automatic logic [15:0] crc_step(input logic [15:0] crc_in, input logic [23:0] data);
        logic [15:0] c;
        c = crc_in;
        for (int i = 23; i >= 0; i--) begin
            if (c[15] ^ data[i]) begin
                c = {c[14:0], 1'b0} ^ 16'h1021;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

    // Accumulate in the same cycle the pixel is registered; publish one cycle after frame_done
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            crc_acc     <= 16'hFFFF;
            o_frame_crc <= '0;
        end else begin
            if (pix_take) begin
                crc_acc <= crc_step(first_pix ? 16'hFFFF : crc_acc, i_rgb);
            end else if ((state == LOCKED) && !locked_nxt) begin
                crc_acc <= 16'hFFFF;
            end
            if (o_frame_done) begin
                o_frame_crc <= crc_acc;
            end
        end
    end
`else
    logic unused_first_pix;
    assign unused_first_pix = first_pix;
    assign o_frame_crc      = 16'h0;
`endif

endmodule

// File: tb/tb_lcd_frame_monitor.sv
// Randomized bench for lcd_frame_monitor using a linear-position reference model on a reduced raster.
// Define LCD_MONITOR_FRAME_CRC_EN for both bench and RTL to check the frame CRC.
module tb_lcd_frame_monitor;

    localparam int H  = 24;
    localparam int V  = 12;
    localparam int HS = 4;
    localparam int HW = 16;
    localparam int VS = 2;
    localparam int VH = 8;
    localparam int XW = 5;
    localparam int YW = 4;
    localparam int FW = 3;
    localparam int LF = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          hsd = 1'b1;
    logic          vsd = 1'b1;
    logic [23:0]   rgb = '0;
    logic          locked;
    logic          pix_vld;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic [23:0]   pix_rgb;
    logic          frame_done;
    logic [FW-1:0] frame_cnt;
    logic          err_h;
    logic          err_v;
    logic [15:0]   frame_crc;

    lcd_frame_monitor #(
        .H_TOTAL(H), .V_TOTAL(V), .H_ACT_START(HS), .H_ACT_W(HW),
        .V_ACT_START(VS), .V_ACT_H(VH), .XW(XW), .YW(YW), .FCNT_W(FW), .LOCK_FRAMES(LF)
    ) dut (
        .i_clk(clk), .i_rstn(rst_n), .i_hsd(hsd), .i_vsd(vsd), .i_rgb(rgb),
        .o_locked(locked), .o_pix_vld(pix_vld), .o_pix_x(pix_x), .o_pix_y(pix_y),
        .o_pix_rgb(pix_rgb), .o_frame_done(frame_done), .o_frame_cnt(frame_cnt),
        .o_err_h(err_h), .o_err_v(err_v), .o_frame_crc(frame_crc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit rgb_zero = 1'b0;

    // Reference model state: raster position as one linear index y*H+x
    int          m_pos, m_st, m_clean, m_cnt;
    bit          m_rh, m_rv, m_bad;
    logic [15:0] m_acc;
    bit          e_locked, e_vld, e_done, e_eh, e_ev;
    int          e_x, e_y;
    logic [23:0] e_rgb;
    logic [15:0] e_crc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [15:0] crc_bytes(input logic [15:0] c_in, input logic [23:0] d);
        logic [15:0] c;
        c = c_in;
        for (int b = 2; b >= 0; b--) begin
            logic [7:0] byt;
            byt = d[b*8 +: 8];
            c = c ^ {byt, 8'h00};
            for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    task automatic model_reset();
        m_pos = 0; m_st = 0; m_clean = 0; m_cnt = 0;
        m_rh = 1; m_rv = 1; m_bad = 0; m_acc = 16'hFFFF;
        e_locked = 0; e_vld = 0; e_done = 0; e_eh = 0; e_ev = 0;
        e_x = 0; e_y = 0; e_rgb = '0; e_crc = '0;
    endtask

    task automatic model_step(input bit h, input bit v, input logic [23:0] d);
        bit fh, fv, err, was_locked;
        int px, py, npos, rx, ry;
        fh = m_rh && !h;
        fv = m_rv && !v;
        m_rh = h; m_rv = v;
        px = m_pos % H; py = m_pos / H;
        if (fv)      npos = 0;
        else if (fh) npos = ((py + 1) % V) * H;
        else         npos = (m_pos + 1) % (H * V);
        e_eh = (m_st != 0) && fh && (px != H - 1);
        e_ev = (m_st != 0) && fv && (m_pos != H * V - 1);
        err  = e_eh || e_ev;
        case (m_st)
            0: if (fv) begin m_st = 1; m_clean = 0; m_bad = 0; end
            1: begin
                if (fv) begin
                    if (!err && !m_bad) m_clean++; else m_clean = 0;
                    m_bad = 0;
                    if (m_clean >= LF) begin m_st = 2; m_clean = 0; end
                end else if (err) begin
                    m_clean = 0; m_bad = 1;
                end
            end
            default: if (err) begin m_st = 1; m_clean = 0; m_bad = !fv; end
        endcase
        m_pos = npos;
        was_locked = e_locked;
        e_locked = (m_st == 2);
        if (e_done) e_crc = m_acc;
        rx = (m_pos % H) - HS;
        ry = (m_pos / H) - VS;
        e_vld  = e_locked && rx >= 0 && rx < HW && ry >= 0 && ry < VH;
        e_done = 0;
        if (e_vld) begin
            e_x = rx; e_y = ry; e_rgb = d;
            m_acc = crc_bytes((rx == 0 && ry == 0) ? 16'hFFFF : m_acc, d);
            if (rx == HW - 1 && ry == VH - 1) begin
                e_done = 1;
                m_cnt = (m_cnt + 1) % (1 << FW);
            end
        end else if (was_locked && !e_locked) begin
            m_acc = 16'hFFFF;
        end
    endtask

    task automatic compare_all();
        check("locked", 32'(locked), 32'(e_locked));
        check("pix_vld", 32'(pix_vld), 32'(e_vld));
        check("err_h", 32'(err_h), 32'(e_eh));
        check("err_v", 32'(err_v), 32'(e_ev));
        check("frame_done", 32'(frame_done), 32'(e_done));
        check("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
        check("pix_x", 32'(pix_x), 32'(e_x));
        check("pix_y", 32'(pix_y), 32'(e_y));
        check("pix_rgb", 32'(pix_rgb), 32'(e_rgb));
`ifdef LCD_MONITOR_FRAME_CRC_EN
        check("frame_crc", 32'(frame_crc), 32'(e_crc));
`else
        check("frame_crc", 32'(frame_crc), 32'h0);
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_locked"}, 32'(locked), 32'h0);
        check({tag, "_vld"}, 32'(pix_vld), 32'h0);
        check({tag, "_x"}, 32'(pix_x), 32'h0);
        check({tag, "_y"}, 32'(pix_y), 32'h0);
        check({tag, "_rgb"}, 32'(pix_rgb), 32'h0);
        check({tag, "_done"}, 32'(frame_done), 32'h0);
        check({tag, "_cnt"}, 32'(frame_cnt), 32'h0);
        check({tag, "_errs"}, {30'h0, err_h, err_v}, 32'h0);
        check({tag, "_crc"}, 32'(frame_crc), 32'h0);
    endtask

    task automatic tick(input bit h, input bit v, input logic [23:0] d);
        @(negedge clk);
        hsd = h; vsd = v; rgb = d;
        @(posedge clk);
        model_step(h, v, d);
        #1;
        compare_all();
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One frame: n_lines lines, one line optionally bad_len long, optional HSD-less lines, optional reset
    task automatic send_frame(input int n_lines, input int bad_line, input int bad_len,
                              input int nohs_from, input int nohs_cnt, input int rst_line);
        for (int l = 0; l < n_lines; l++) begin
            int  len;
            bit  hs_on;
            len   = (l == bad_line) ? bad_len : H;
            hs_on = !(l >= nohs_from && l < nohs_from + nohs_cnt);
            for (int c = 0; c < len; c++) begin
                logic [23:0] d;
                d = rgb_zero ? 24'h0 : 24'($urandom);
                tick(!(hs_on && c < 2), !(l < 2), d);
                if (l == rst_line && c == 10) async_reset();
            end
        end
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        repeat (4) send_frame(V, -1, 0, -1, 0, -1);        // lock and stream
        send_frame(V, 5, H - 1, -1, 0, -1);                 // short line -> err_h
        repeat (3) send_frame(V, -1, 0, -1, 0, -1);
        send_frame(V - 2, -1, 0, -1, 0, -1);                // short frame -> err_v
        repeat (3) send_frame(V, -1, 0, -1, 0, -1);
        send_frame(V, -1, 0, -1, 0, 6);                     // async reset mid-frame
        repeat (3) send_frame(V, -1, 0, -1, 0, -1);
        send_frame(V, -1, 0, 3, 2, -1);                     // free-run without HSD
        send_frame(V, -1, 0, -1, 0, -1);
        rgb_zero = 1'b1;
        repeat (3) send_frame(V, -1, 0, -1, 0, -1);         // constant black frames
        rgb_zero = 1'b0;

        for (int f = 0; f < 10; f++) begin
            int nl, bl, blen, nf;
            nl   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(V - 3, V + 1)) : V;
            bl   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, V - 4)) : -1;
            blen = int'($urandom_range(H - 3, H + 3));
            nf   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, V - 3)) : -1;
            send_frame(nl, bl, blen, nf, 1, -1);
        end
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 7) != 0, $urandom_range(0, 40) != 0, 24'($urandom));
        end
        repeat (3) send_frame(V, -1, 0, -1, 0, -1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
